// File: rtl/pixel_collector.sv
// Pixel collector: captures one batch of engine results and streams it out
// in raster order, marking the first and last pixel of each frame.
module pixel_collector #(
  parameter int                          PIXEL_DATA_WIDTH = 10,
  parameter logic [PIXEL_DATA_WIDTH-1:0] SCREEN_WIDTH     = 10'd640,
  parameter logic [PIXEL_DATA_WIDTH-1:0] SCREEN_HEIGHT    = 10'd480,
  parameter int                          NUM_ENGINES      = 12,
  parameter int                          RESULT_WIDTH     = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    res_valid,
  input  logic [RESULT_WIDTH-1:0] res_data [NUM_ENGINES],
  output logic                    res_ready,
  output logic                    fin_flag,
  output logic [RESULT_WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_sop,
  output logic                    out_eop
);

  localparam int IDX_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
  localparam logic [IDX_W-1:0]            LAST_IDX = IDX_W'(NUM_ENGINES - 1);
  localparam logic [PIXEL_DATA_WIDTH-1:0] X_LAST   = SCREEN_WIDTH - 1'b1;
  localparam logic [PIXEL_DATA_WIDTH-1:0] Y_LAST   = SCREEN_HEIGHT - 1'b1;

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t                      state, state_next;
  logic [RESULT_WIDTH-1:0]     buffer [NUM_ENGINES];
  logic [IDX_W-1:0]            idx;
  logic [PIXEL_DATA_WIDTH-1:0] x, y;
  logic                        capture, xfer, last_xfer;

  // res_ready is gated by reset so no batch can be accepted while in reset
  always_comb begin
    state_next = state;
    res_ready  = 1'b0;
    out_valid  = 1'b0;
    capture    = 1'b0;
    xfer       = 1'b0;
    last_xfer  = 1'b0;
    case (state)
      IDLE: begin
        res_ready = reset;
        capture   = reset && res_valid;
        if (capture) state_next = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        xfer      = out_ready;
        last_xfer = out_ready && (idx == LAST_IDX);
        if (last_xfer) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      idx      <= '0;
      x        <= '0;
      y        <= '0;
      fin_flag <= 1'b0;
    end else begin
      state    <= state_next;
      fin_flag <= capture;
      if (capture) begin
        idx <= '0;
      end else if (xfer) begin
        idx <= last_xfer ? '0 : idx + 1'b1;
        if (x == X_LAST) begin
          x <= '0;
          y <= (y == Y_LAST) ? '0 : y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
    end
  end

  // The buffer needs no reset: it is only observable while in DRAIN
  always_ff @(posedge clk) begin
    if (capture) buffer <= res_data;
  end

  assign out_data = out_valid ? buffer[idx] : '0;
  assign out_sop  = out_valid && (x == '0) && (y == '0);
  assign out_eop  = out_valid && (x == X_LAST) && (y == Y_LAST);

endmodule

// File: tb/tb_pixel_collector.sv
// Bench for pixel_collector: default instance plus two small-screen
// instances for frame-boundary behaviour.
module tb_pixel_collector;

  typedef struct {
    logic       res_valid;
    logic       out_ready;
    logic       exp_ready;
    logic       exp_fin;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_sop;
    logic       exp_eop;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       res_valid_a, res_ready_a, fin_a, out_valid_a, out_ready_a, sop_a, eop_a;
  logic [7:0] res_data_a [12];
  logic [7:0] out_data_a;

  logic       res_valid_b, res_ready_b, fin_b, out_valid_b, out_ready_b, sop_b, eop_b;
  logic [7:0] res_data_b [5];
  logic [7:0] out_data_b;

  logic       res_valid_c, res_ready_c, fin_c, out_valid_c, out_ready_c, sop_c, eop_c;
  logic [7:0] res_data_c [12];
  logic [7:0] out_data_c;

  int errors = 0;
  int checks = 0;
  vec_t vecs [13];

  pixel_collector dut_a (
    .clk(clk), .reset(reset), .res_valid(res_valid_a), .res_data(res_data_a),
    .res_ready(res_ready_a), .fin_flag(fin_a), .out_data(out_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_sop(sop_a), .out_eop(eop_a)
  );

  pixel_collector #(
    .PIXEL_DATA_WIDTH(10), .SCREEN_WIDTH(10'd4), .SCREEN_HEIGHT(10'd3),
    .NUM_ENGINES(5), .RESULT_WIDTH(8)
  ) dut_b (
    .clk(clk), .reset(reset), .res_valid(res_valid_b), .res_data(res_data_b),
    .res_ready(res_ready_b), .fin_flag(fin_b), .out_data(out_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_sop(sop_b), .out_eop(eop_b)
  );

  pixel_collector #(
    .PIXEL_DATA_WIDTH(10), .SCREEN_WIDTH(10'd48), .SCREEN_HEIGHT(10'd20),
    .NUM_ENGINES(12), .RESULT_WIDTH(8)
  ) dut_c (
    .clk(clk), .reset(reset), .res_valid(res_valid_c), .res_data(res_data_c),
    .res_ready(res_ready_c), .fin_flag(fin_c), .out_data(out_data_c),
    .out_valid(out_valid_c), .out_ready(out_ready_c), .out_sop(sop_c), .out_eop(eop_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int k);
    res_valid_a = v.res_valid;
    out_ready_a = v.out_ready;
    tick();
    checkOutput($sformatf("vec%0d_ready", k), int'(res_ready_a), int'(v.exp_ready));
    checkOutput($sformatf("vec%0d_fin",   k), int'(fin_a),       int'(v.exp_fin));
    checkOutput($sformatf("vec%0d_valid", k), int'(out_valid_a), int'(v.exp_valid));
    checkOutput($sformatf("vec%0d_data",  k), int'(out_data_a),  int'(v.exp_data));
    checkOutput($sformatf("vec%0d_sop",   k), int'(sop_a),       int'(v.exp_sop));
    checkOutput($sformatf("vec%0d_eop",   k), int'(eop_a),       int'(v.exp_eop));
  endtask

  initial begin
    int got, fins, pix, sops, eops, eop_pix;

    // Single batch of 1..12 with out_ready held high
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd1, 1'b1, 1'b0};
    for (int k = 1; k < 12; k++)
      vecs[k] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'(k + 1), 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0};

    reset = 1'b0;
    res_valid_a = 1'b0; out_ready_a = 1'b0;
    res_valid_b = 1'b0; out_ready_b = 1'b0;
    res_valid_c = 1'b0; out_ready_c = 1'b0;
    for (int i = 0; i < 12; i++) begin
      res_data_a[i] = 8'(i + 1);
      res_data_c[i] = 8'd0;
    end
    for (int i = 0; i < 5; i++) res_data_b[i] = 8'd0;

    tick();
    res_valid_a = 1'b1;
    tick();
    checkOutput("rst_ready", int'(res_ready_a), 0);
    checkOutput("rst_valid", int'(out_valid_a), 0);
    checkOutput("rst_fin",   int'(fin_a),       0);
    checkOutput("rst_data",  int'(out_data_a),  0);
    checkOutput("rst_sop",   int'(sop_a),       0);
    checkOutput("rst_eop",   int'(eop_a),       0);
    res_valid_a = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("rst_release_ready", int'(res_ready_a), 1);

    for (int k = 0; k < 13; k++) applyStimulus(vecs[k], k);

    // Backpressure: out_ready follows 1,0,0,1
    for (int i = 0; i < 12; i++) res_data_a[i] = 8'(100 + i);
    res_valid_a = 1'b1; out_ready_a = 1'b1;
    tick();
    res_valid_a = 1'b0;
    checkOutput("bp_fin", int'(fin_a), 1);
    got = 0; fins = 0;
    for (int c = 0; c < 200 && got < 12; c++) begin
      out_ready_a = ((c % 4) == 0) || ((c % 4) == 3);
      if (c > 0 && fin_a) fins++;
      checkOutput("bp_valid", int'(out_valid_a), 1);
      checkOutput("bp_data", int'(out_data_a), 100 + got);
      checkOutput("bp_sop", int'(sop_a), 0);
      if (out_ready_a) got++;
      tick();
    end
    checkOutput("bp_count", got, 12);
    checkOutput("bp_extra_fin", fins, 0);
    checkOutput("bp_end_valid", int'(out_valid_a), 0);
    checkOutput("bp_end_ready", int'(res_ready_a), 1);

    // res_valid stays high through DRAIN; res_data changes must not leak in
    for (int i = 0; i < 12; i++) res_data_a[i] = 8'(30 + i);
    res_valid_a = 1'b1; out_ready_a = 1'b1;
    tick();
    checkOutput("hold_fin0", int'(fin_a), 1);
    for (int i = 0; i < 12; i++) res_data_a[i] = 8'(40 + i);
    fins = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (fin_a) fins++;
      if (c < 12) begin
        checkOutput("hold_data", int'(out_data_a), 30 + c);
        checkOutput("hold_ready", int'(res_ready_a), 0);
      end
    end
    checkOutput("hold_extra_fin", fins, 0);
    checkOutput("hold_idle_ready", int'(res_ready_a), 1);
    tick();
    checkOutput("hold_fin1", int'(fin_a), 1);
    checkOutput("hold_new_data", int'(out_data_a), 40);
    res_valid_a = 1'b0;
    for (int c = 0; c < 12; c++) tick();
    checkOutput("hold_drained", int'(out_valid_a), 0);

    // Reset in the middle of a batch at idx 6
    for (int i = 0; i < 12; i++) res_data_a[i] = 8'(50 + i);
    res_valid_a = 1'b1;
    tick();
    res_valid_a = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    checkOutput("mid_data_idx6", int'(out_data_a), 56);
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_ready", int'(res_ready_a), 0);
    tick();
    checkOutput("mid_rst_valid", int'(out_valid_a), 0);
    checkOutput("mid_rst_data", int'(out_data_a), 0);
    reset = 1'b1;
    #1;
    checkOutput("mid_release_ready", int'(res_ready_a), 1);
    for (int i = 0; i < 12; i++) res_data_a[i] = 8'(70 + i);
    res_valid_a = 1'b1;
    tick();
    res_valid_a = 1'b0;
    checkOutput("mid_new_fin", int'(fin_a), 1);
    checkOutput("mid_new_sop", int'(sop_a), 1);
    checkOutput("mid_new_data", int'(out_data_a), 70);
    for (int c = 0; c < 12; c++) tick();
    checkOutput("mid_new_done", int'(res_ready_a), 1);

    // 4x3 screen, 5 engines, three batches straddling the frame boundary
    for (int i = 0; i < 5; i++) res_data_b[i] = 8'(i);
    res_valid_b = 1'b1; out_ready_b = 1'b1;
    fins = 0; pix = 0;
    for (int c = 0; c < 200 && pix < 15; c++) begin
      tick();
      if (fin_b) begin
        fins++;
        if (fins == 3) res_valid_b = 1'b0;
        else for (int i = 0; i < 5; i++) res_data_b[i] = 8'(fins * 10 + i);
      end
      if (out_valid_b) begin
        checkOutput($sformatf("small_p%0d_data", pix + 1), int'(out_data_b), (pix / 5) * 10 + pix % 5);
        checkOutput($sformatf("small_p%0d_sop", pix + 1), int'(sop_b), int'(pix == 0 || pix == 12));
        checkOutput($sformatf("small_p%0d_eop", pix + 1), int'(eop_b), int'(pix == 11));
        pix++;
      end
    end
    checkOutput("small_pixels", pix, 15);
    checkOutput("small_fins", fins, 3);

    // Full 48x20 frame of 80 batches
    res_valid_c = 1'b1; out_ready_c = 1'b1;
    fins = 0; pix = 0; sops = 0; eops = 0; eop_pix = -1;
    for (int c = 0; c < 3000 && pix < 960; c++) begin
      tick();
      if (fin_c) begin
        fins++;
        if (fins == 80) res_valid_c = 1'b0;
      end
      if (out_valid_c) begin
        if (sop_c) sops++;
        if (eop_c) begin
          eops++;
          eop_pix = pix;
        end
        pix++;
      end
    end
    checkOutput("frame_pixels", pix, 960);
    checkOutput("frame_fins", fins, 80);
    checkOutput("frame_sop_count", sops, 1);
    checkOutput("frame_eop_count", eops, 1);
    checkOutput("frame_eop_pixel", eop_pix, 959);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
